// File: rtl/pred_update_sched_pkg.sv
// Shared constants for the predictor update scheduler: index width and default queue depth.
`ifndef PRED_TABLE_BIT
`define PRED_TABLE_BIT 8
`endif
`ifndef PRED_UPD_DEPTH
`define PRED_UPD_DEPTH 4
`endif

package pred_update_sched_pkg;
    localparam int PRED_IND_W    = `PRED_TABLE_BIT;
    localparam int UPD_DEPTH_DEF = `PRED_UPD_DEPTH;

    function automatic logic [1:0] n_valid(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction
endpackage

// File: rtl/pred_upd_fifo.sv
// Circular buffer with two write ports and one read port.
// Both writes land in consecutive slots starting at tail.
module pred_upd_fifo
    import pred_update_sched_pkg::*;
#(
    parameter int DEPTH = UPD_DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int W     = 2 + 2 * PRED_IND_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_i,
    input  logic [1:0]       wr_n_i,
    input  logic [W-1:0]     wr0_data_i,
    input  logic [W-1:0]     wr1_data_i,
    input  logic             rd_i,
    output logic [W-1:0]     head_o,
    output logic [PTR_W:0]   count_o
);
    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q, tail1;
    logic [PTR_W:0]   count_q;

    assign tail1   = tail_q + 1'b1;
    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

    // Storage is cleared so every output reads 0 while reset is held.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (en_i) begin
            if (wr_n_i != 2'd0) mem_q[tail_q] <= wr0_data_i;
            if (wr_n_i == 2'd2) mem_q[tail1]  <= wr1_data_i;
            if (rd_i) head_q <= head_q + 1'b1;
            tail_q  <= tail_q + PTR_W'(wr_n_i);
            count_q <= count_q + (PTR_W+1)'(wr_n_i) - (PTR_W+1)'(rd_i);
        end
    end
endmodule

// File: rtl/pred_update_sched.sv
// Serialises up to two committed branch updates per cycle into the single
// predictor update port, in commit order, with saturating perf counters.
module pred_update_sched
    import pred_update_sched_pkg::*;
#(
    parameter int DEPTH = UPD_DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int IND_W = PRED_IND_W,
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             c0_valid_in,
    input  logic             c0_res_in,
    input  logic             c0_correct_in,
    input  logic [IND_W-1:0] c0_g_ind_in,
    input  logic [IND_W-1:0] c0_l_ind_in,
    input  logic             c1_valid_in,
    input  logic             c1_res_in,
    input  logic             c1_correct_in,
    input  logic [IND_W-1:0] c1_g_ind_in,
    input  logic [IND_W-1:0] c1_l_ind_in,
    output logic             commit_stall_out,
    output logic             br_req_out,
    output logic             br_res_out,
    output logic             br_correct_out,
    output logic [IND_W-1:0] br_g_ind_out,
    output logic [IND_W-1:0] br_l_ind_out,
    output logic [CNT_W-1:0] br_cnt_out,
    output logic [CNT_W-1:0] mispred_cnt_out,
    output logic             ovf_err_out
);
    localparam int EW = 2 + 2 * IND_W;

    logic [EW-1:0]    e0, e1, first, head;
    logic [PTR_W:0]   count, free;
    logic [1:0]       n_in, n_acc;
    logic             deq, ovf;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
    logic             ovf_q, ovf_d;

    assign e0 = {c0_res_in, c0_correct_in, c0_g_ind_in, c0_l_ind_in};
    assign e1 = {c1_res_in, c1_correct_in, c1_g_ind_in, c1_l_ind_in};
    // A lone slot-1 branch takes the tail slot, so age order is preserved.
    assign first = c0_valid_in ? e0 : e1;

    // Room is judged on the registered count; this cycle's drain doesn't help.
    assign free  = (PTR_W+1)'(DEPTH) - count;
    assign n_in  = n_valid(c0_valid_in, c1_valid_in);
    assign ovf   = (PTR_W+1)'(n_in) > free;
    assign n_acc = ovf ? free[1:0] : n_in;
    assign deq   = count != '0;

    pred_upd_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(EW)) u_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .en_i       (rdy_in),
        .wr_n_i     (n_acc),
        .wr0_data_i (first),
        .wr1_data_i (e1),
        .rd_i       (deq),
        .head_o     (head),
        .count_o    (count)
    );

    assign commit_stall_out = count > (PTR_W+1)'(DEPTH - 2);
    assign br_req_out       = deq;
    assign br_res_out       = head[EW-1];
    assign br_correct_out   = head[EW-2];
    assign br_g_ind_out     = head[2*IND_W-1:IND_W];
    assign br_l_ind_out     = head[IND_W-1:0];
    assign br_cnt_out       = br_cnt_q;
    assign mispred_cnt_out  = mis_cnt_q;
    assign ovf_err_out      = ovf_q;

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        ovf_d     = ovf_q;
        if (rdy_in) begin
            if (ovf) ovf_d = 1'b1;
            if (deq) begin
                if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 1'b1;
                if (!head[EW-2] && mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
            ovf_q     <= ovf_d;
        end
    end
endmodule
